// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with run-time reloadable pattern and overlap mode.
// Optional saturating match counter is built only when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_param #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
  parameter bit               OVERLAP  = 1'b1,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  typedef enum logic {FILL, HUNT} state_t;

  state_t            state, state_next;
  logic [PAT_W-1:0]  win, win_next, pat_r, pat_next, shifted;
  logic [FILL_W-1:0] fill, fill_next;
  logic              ovl_r, ovl_next;
  logic              match, window_full;

  assign shifted = {win[PAT_W-2:0], x};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      win   <= '0;
      fill  <= '0;
      pat_r <= PAT_INIT;
      ovl_r <= OVERLAP;
      z     <= 1'b0;
    end else begin
      state <= state_next;
      win   <= win_next;
      fill  <= fill_next;
      pat_r <= pat_next;
      ovl_r <= ovl_next;
      z     <= match;
    end
  end

  // A reload discards the coincident bit; otherwise a valid bit shifts in and may complete a match.
  always_comb begin
    state_next  = state;
    win_next    = win;
    fill_next   = fill;
    pat_next    = pat_r;
    ovl_next    = ovl_r;
    match       = 1'b0;
    window_full = 1'b0;
    if (cfg_we) begin
      pat_next   = cfg_pat;
      ovl_next   = cfg_overlap;
      win_next   = '0;
      fill_next  = '0;
      state_next = FILL;
    end else if (x_valid) begin
      win_next    = shifted;
      window_full = (state == HUNT) || (fill == FILL_LAST);
      if (state == FILL) begin
        fill_next = fill + FILL_W'(1);
        if (fill == FILL_LAST) state_next = HUNT;
      end else begin
        fill_next = FILL_FULL;
      end
      match = window_full && (shifted == pat_r);
      if (match && !ovl_r) begin
        fill_next  = '0;
        state_next = FILL;
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Clear beats a coincident match; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt <= '0;
    end else if (match && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule
